// File: rtl/cdc_handshake_tx_pkg.sv
// Shared definitions for the toggle-handshake CDC transmit/receive pair.
package cdc_handshake_tx_pkg;

  // Handshake FSM state encoding, shared with the matching receive block.
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] SETUP    = 2'd1;
  localparam logic [1:0] WAIT_ACK = 2'd2;

  // Bits needed to hold values 0..max_val, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    int unsigned w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/cdc_handshake_tx_sync.sv
// Multi-flop synchronizer bringing an asynchronous signal into the ck domain.
module cdc_handshake_tx_sync #(
  parameter int unsigned D_WIDTH = 1,
  parameter int unsigned SYNC_FF = 2
) (
  input  logic               ck,
  input  logic               rn,
  input  logic [D_WIDTH-1:0] d,
  output logic [D_WIDTH-1:0] q
);

  logic [SYNC_FF-1:0][D_WIDTH-1:0] sr;

  // Shift the asynchronous input through SYNC_FF flops; oldest stage is the output.
  always_ff @(posedge ck) begin
    if (!rn) begin
      sr <= '0;
    end else begin
      sr <= {sr[SYNC_FF-2:0], d};
    end
  end

  assign q = sr[SYNC_FF-1];

endmodule

// File: rtl/cdc_handshake_tx.sv
// Source-domain end of a toggle-handshake CDC: holds a word on tx_data,
// toggles tx_req after a setup delay and waits for the returned ack toggle.
module cdc_handshake_tx
  import cdc_handshake_tx_pkg::*;
#(
  parameter int unsigned D_WIDTH     = 64,
  parameter int unsigned SYNC_FF     = 2,
  parameter int unsigned SETUP_CYC   = 1,
  parameter int unsigned TIMEOUT_CYC = 0
) (
  input  logic               ck,
  input  logic               rn,
  input  logic [D_WIDTH-1:0] s_data,
  input  logic               s_valid,
  output logic               s_ready,
  output logic [D_WIDTH-1:0] tx_data,
  output logic               tx_req,
  input  logic               rx_ack,
  output logic               busy,
  output logic               timeout_err,
  input  logic               err_clr
);

  localparam int unsigned SETUP_W = cnt_width(SETUP_CYC);
  localparam int unsigned TO_W    = cnt_width(TIMEOUT_CYC);
  localparam bit          TO_EN   = (TIMEOUT_CYC != 0);
  localparam logic [SETUP_W-1:0] SETUP_LOAD = SETUP_W'(SETUP_CYC - 32'd1);
  localparam logic [TO_W-1:0]    TO_LAST    = TO_W'(TO_EN ? TIMEOUT_CYC - 32'd1 : 32'd0);

  logic [1:0]         state;
  logic [1:0]         state_nxt;
  logic [D_WIDTH-1:0] data_nxt;
  logic               req_nxt;
  logic [SETUP_W-1:0] setup_cnt;
  logic [SETUP_W-1:0] setup_cnt_nxt;
  logic [TO_W-1:0]    to_cnt;
  logic [TO_W-1:0]    to_cnt_nxt;
  logic               err_nxt;
  logic               to_hit;
  logic               ack_s;

  // Bring the asynchronous acknowledge toggle into the ck domain.
  cdc_handshake_tx_sync #(
    .D_WIDTH (1),
    .SYNC_FF (SYNC_FF)
  ) u_ack_sync (
    .ck (ck),
    .rn (rn),
    .d  (rx_ack),
    .q  (ack_s)
  );

  // Handshake decode straight from registers (plus reset gating on ready).
  assign s_ready = (state == IDLE) && rn;
  assign busy    = (state != IDLE);

  // Next-state logic: accept, setup countdown, then wait for the matching ack parity.
  always_comb begin
    state_nxt     = state;
    data_nxt      = tx_data;
    req_nxt       = tx_req;
    setup_cnt_nxt = setup_cnt;
    to_cnt_nxt    = to_cnt;
    to_hit        = 1'b0;
    case (state)
      IDLE: begin
        if (s_valid && s_ready) begin
          data_nxt      = s_data;
          setup_cnt_nxt = SETUP_LOAD;
          state_nxt     = SETUP;
        end
      end
      SETUP: begin
        if (setup_cnt != '0) begin
          setup_cnt_nxt = setup_cnt - SETUP_W'(1);
        end else begin
          req_nxt    = ~tx_req;
          to_cnt_nxt = '0;
          state_nxt  = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        // Timeout only flags; the block keeps waiting so toggle parity stays aligned.
        if (TO_EN && (to_cnt == TO_LAST)) begin
          to_hit = 1'b1;
        end
        if (ack_s == tx_req) begin
          state_nxt = IDLE;
        end else if (to_cnt != '1) begin
          to_cnt_nxt = to_cnt + TO_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    // A new timeout outranks a same-cycle clear.
    if (to_hit) begin
      err_nxt = 1'b1;
    end else if (err_clr) begin
      err_nxt = 1'b0;
    end else begin
      err_nxt = timeout_err;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge ck) begin
    if (!rn) begin
      state       <= IDLE;
      tx_data     <= '0;
      tx_req      <= 1'b0;
      setup_cnt   <= '0;
      to_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      tx_data     <= data_nxt;
      tx_req      <= req_nxt;
      setup_cnt   <= setup_cnt_nxt;
      to_cnt      <= to_cnt_nxt;
      timeout_err <= err_nxt;
    end
  end

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Self-checking bench for cdc_handshake_tx: directed scenarios plus randomized
// traffic, compared every cycle against a transaction-level reference model.
module tb_cdc_handshake_tx;

  localparam int unsigned DW = 64;
  localparam int SF = 2;
  localparam int SC = 1;
  localparam int TC = 8;

  logic          ck = 1'b0;
  logic          rn;
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] tx_data;
  logic          tx_req;
  logic          rx_ack;
  logic          busy;
  logic          timeout_err;
  logic          err_clr;
  logic          loopback;
  logic          ack_drv;
  bit            cmp_en = 1'b0;

  int total = 0;
  int bad   = 0;

  cdc_handshake_tx #(
    .D_WIDTH     (DW),
    .SYNC_FF     (SF),
    .SETUP_CYC   (SC),
    .TIMEOUT_CYC (TC)
  ) dut (
    .ck          (ck),
    .rn          (rn),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .tx_data     (tx_data),
    .tx_req      (tx_req),
    .rx_ack      (rx_ack),
    .busy        (busy),
    .timeout_err (timeout_err),
    .err_clr     (err_clr)
  );

  always #5 ck = ~ck;

  // Destination emulation: either a direct echo of the request or a driven value.
  assign rx_ack = loopback ? tx_req : ack_drv;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one transfer at a time, timed by edge numbers.
  int            n = 0;
  bit            m_busy = 1'b0;
  bit            m_wait = 1'b0;
  bit            m_req  = 1'b0;
  bit            m_tout = 1'b0;
  logic [DW-1:0] m_data = '0;
  int            m_toggle_at = 0;
  int            m_wait_start = 0;
  bit            ackq[$];

  always @(posedge ck) begin
    bit ack_seen;
    bit hit;
    n++;
    if (!rn) begin
      m_busy = 1'b0;
      m_wait = 1'b0;
      m_req  = 1'b0;
      m_tout = 1'b0;
      m_data = '0;
      ackq.delete();
      for (int i = 0; i < SF; i++) ackq.push_back(1'b0);
    end else begin
      // The block sees the ack value sampled SF edges earlier.
      ack_seen = ackq.pop_front();
      ackq.push_back(rx_ack);
      hit = 1'b0;
      if (!m_busy) begin
        if (s_valid) begin
          m_busy      = 1'b1;
          m_wait      = 1'b0;
          m_data      = s_data;
          m_toggle_at = n + SC;
        end
      end else if (!m_wait) begin
        if (n == m_toggle_at) begin
          m_req        = ~m_req;
          m_wait       = 1'b1;
          m_wait_start = n;
        end
      end else begin
        if (TC != 0 && (n - m_wait_start) == TC) hit = 1'b1;
        if (ack_seen == m_req) begin
          m_busy = 1'b0;
          m_wait = 1'b0;
        end
      end
      if (hit) m_tout = 1'b1;
      else if (err_clr) m_tout = 1'b0;
    end
  end

  // Compare all outputs against the model mid-cycle.
  always @(negedge ck) begin
    if (cmp_en) begin
      chk("m_s_ready", 64'(s_ready), 64'(m_busy == 1'b0 && rn == 1'b1));
      chk("m_busy", 64'(busy), 64'(m_busy));
      chk("m_tx_req", 64'(tx_req), 64'(m_req));
      chk("m_tx_data", 64'(tx_data), 64'(m_data));
      chk("m_timeout_err", 64'(timeout_err), 64'(m_tout));
    end
  end

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic wait_idle(input string name, input int limit);
    int k;
    k = 0;
    while (busy && k < limit) begin
      tick();
      k++;
    end
    chk(name, 64'(busy), 64'd0);
  endtask

  logic [DW-1:0] words [3];
  logic          exp_req [3];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rn = 1'b0; s_valid = 1'b0; s_data = '0; err_clr = 1'b0;
    loopback = 1'b1; ack_drv = 1'b0;
    words[0] = 64'h1111_2222_3333_4444;
    words[1] = 64'hAAAA_5555_F0F0_0F0F;
    words[2] = 64'h0123_4567_89AB_CDEF;
    exp_req[0] = 1'b1; exp_req[1] = 1'b0; exp_req[2] = 1'b1;

    // Reset and release.
    repeat (3) tick();
    chk("rst_s_ready_low", 64'(s_ready), 64'd0);
    cmp_en = 1'b1;
    rn = 1'b1;
    tick();
    chk("rel_tx_req", 64'(tx_req), 64'd0);
    chk("rel_tx_data", 64'(tx_data), 64'd0);
    chk("rel_busy", 64'(busy), 64'd0);
    chk("rel_timeout_err", 64'(timeout_err), 64'd0);
    chk("rel_s_ready", 64'(s_ready), 64'd1);

    // Single transfer under loopback.
    s_data = 64'hDEAD_BEEF_0123_4567; s_valid = 1'b1;
    tick();
    chk("e0_tx_data", 64'(tx_data), 64'hDEAD_BEEF_0123_4567);
    chk("e0_tx_req", 64'(tx_req), 64'd0);
    chk("e0_busy", 64'(busy), 64'd1);
    s_valid = 1'b0; s_data = '0;
    tick();
    chk("e1_tx_req", 64'(tx_req), 64'd1);
    tick(); tick();
    chk("e3_busy", 64'(busy), 64'd1);
    tick();
    chk("e4_busy", 64'(busy), 64'd0);
    chk("e4_s_ready", 64'(s_ready), 64'd1);

    // Back-to-back words from a fresh reset.
    rn = 1'b0;
    tick();
    rn = 1'b1;
    s_valid = 1'b1;
    for (int w = 0; w < 3; w++) begin
      s_data = words[w];
      tick();
      chk("b2b_accept_data", 64'(tx_data), 64'(words[w]));
      s_data = ~words[w];
      tick();
      chk("b2b_req", 64'(tx_req), 64'(exp_req[w]));
      tick(); tick(); tick();
      chk("b2b_ready", 64'(s_ready), 64'd1);
      chk("b2b_hold_data", 64'(tx_data), 64'(words[w]));
    end
    s_valid = 1'b0;

    // Timeout with ack stuck, then late ack and clear.
    ack_drv = 1'b1; loopback = 1'b0;
    s_data = 64'h5A5A_5A5A_A5A5_A5A5; s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    repeat (8) tick();
    chk("to_e8_err", 64'(timeout_err), 64'd0);
    chk("to_e8_busy", 64'(busy), 64'd1);
    tick();
    chk("to_e9_err", 64'(timeout_err), 64'd1);
    chk("to_e9_busy", 64'(busy), 64'd1);
    ack_drv = 1'b0;
    wait_idle("to_late_ack_idle", 10);
    chk("to_err_sticky", 64'(timeout_err), 64'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("to_err_cleared", 64'(timeout_err), 64'd0);

    // Reset while waiting for ack.
    s_data = 64'hCAFE_F00D_0000_0001; s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    tick(); tick();
    rn = 1'b0;
    tick();
    chk("mid_rst_tx_req", 64'(tx_req), 64'd0);
    chk("mid_rst_tx_data", 64'(tx_data), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_s_ready", 64'(s_ready), 64'd0);
    rn = 1'b1; ack_drv = 1'b0; loopback = 1'b1;
    s_data = 64'hCAFE_F00D_0000_0002; s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    chk("post_rst_data", 64'(tx_data), 64'hCAFE_F00D_0000_0002);
    wait_idle("post_rst_idle", 10);
    chk("post_rst_req", 64'(tx_req), 64'd1);

    // Stray ack toggle while idle.
    ack_drv = 1'b1; loopback = 1'b0;
    tick();
    ack_drv = 1'b0;
    repeat (4) begin
      tick();
      chk("stray_ready", 64'(s_ready), 64'd1);
      chk("stray_busy", 64'(busy), 64'd0);
    end
    ack_drv = 1'b1;
    repeat (3) tick();

    // Timeout set collides with err_clr.
    s_data = 64'h0F0F_0F0F_0F0F_0F0F; s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    repeat (7) tick();
    err_clr = 1'b1;
    tick();
    chk("coll_e8_err", 64'(timeout_err), 64'd0);
    tick();
    chk("coll_set_wins", 64'(timeout_err), 64'd1);
    err_clr = 1'b0;
    ack_drv = 1'b0;
    wait_idle("coll_idle", 10);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("coll_cleared", 64'(timeout_err), 64'd0);

    // Randomized traffic with a lagging, occasionally misbehaving destination.
    repeat (3000) begin
      tick();
      rn      = ($urandom_range(0, 199) != 0);
      s_valid = 1'($urandom_range(0, 1));
      s_data  = {$urandom, $urandom};
      err_clr = ($urandom_range(0, 7) == 0);
      if (!rn) ack_drv = 1'b0;
      else if ($urandom_range(0, 39) == 0) ack_drv = ~ack_drv;
      else if ($urandom_range(0, 3) == 0) ack_drv = tx_req;
    end
    tick();
    cmp_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cdc_handshake_tx.md
Name: cdc_handshake_tx

Overview:
- Source-domain transmit end of a toggle-handshake clock-domain crossing.
- Accepts a data word on a valid/ready interface and holds it stable on tx_data.
- Toggles tx_req after a setup delay, then waits for the destination's returned toggle on rx_ack. rx_ack is asynchronous and is synchronized internally.
- Pairs with a destination-side receiver that samples tx_data once it sees tx_req change.

Parameters:
- D_WIDTH, 64, width of the transferred data word.
- SYNC_FF, 2, flop stages used to synchronize rx_ack; minimum 2.
- SETUP_CYC, 1, ck edges between the tx_data update and the tx_req toggle; minimum 1.
- TIMEOUT_CYC, 0, WAIT_ACK cycles before timeout_err is set; 0 disables the timeout.

Ports:
- ck  in  1  clock.
- rn  in  1  synchronous active-low reset, sampled on posedge ck.
- s_data  in  D_WIDTH  word to transfer.
- s_valid  in  1  s_data is valid.
- s_ready  out  1  block can accept a word.
- tx_data  out  D_WIDTH  held word to the destination; stable between accepts.
- tx_req  out  1  request toggle, registered.
- rx_ack  in  1  acknowledge toggle from the destination domain; asynchronous.
- busy  out  1  a transfer is in progress.
- timeout_err  out  1  sticky acknowledge-timeout flag.
- err_clr  in  1  clears timeout_err.

Behaviour:
- Reset (rn=0 at posedge ck):
  - state=IDLE; tx_data=0; tx_req=0; all counters=0; timeout_err=0; synchronizer stages=0.
  - s_ready=0 and busy=0 while rn=0.
  - The destination must also be reset so that rx_ack returns to 0.
- Output decode: s_ready = (state==IDLE) && rn. busy = (state!=IDLE). Both decode only from registers; no combinational path from s_valid or rx_ack.
- ack_s is rx_ack after SYNC_FF flops clocked by ck.
- State IDLE:
  - Accept when s_valid && s_ready. On that edge: tx_data <= s_data, setup_cnt <= SETUP_CYC-1, go to SETUP.
  - When not ready, s_data and s_valid are ignored.
- State SETUP:
  - setup_cnt != 0: decrement.
  - setup_cnt == 0: tx_req <= ~tx_req, to_cnt <= 0, go to WAIT_ACK.
  - tx_req therefore toggles exactly SETUP_CYC edges after tx_data changes.
- State WAIT_ACK:
  - ack_s == tx_req: go to IDLE; s_ready is high from the next cycle.
  - Otherwise: to_cnt increments, saturating.
  - If TIMEOUT_CYC != 0 and to_cnt == TIMEOUT_CYC-1: set timeout_err.
  - No abort on timeout; the block keeps waiting so the toggle parity stays consistent.
- Latency, with rx_ack toggling in the same cycle tx_req toggles: s_ready returns SYNC_FF+1 edges after the tx_req toggle.
- Minimum accept-to-accept spacing: SETUP_CYC+SYNC_FF+2 cycles.
- tx_data changes only on an accept edge. Its value is never altered in SETUP or WAIT_ACK.
- An rx_ack change while in IDLE or SETUP does not affect state. It is evaluated only in WAIT_ACK.
- timeout_err:
  - Cleared by err_clr=1.
  - If set and clear occur on the same edge, set wins.
  - Holds through subsequent transfers until cleared.
- Reset mid-transfer (SETUP or WAIT_ACK): immediate return to reset values; the in-flight word is discarded.
- Counter widths:
  - setup_cnt: $clog2(SETUP_CYC+1).
  - to_cnt: $clog2(TIMEOUT_CYC+1), minimum 1 bit.

Decomposition:
- Shared package:
  - State encoding localparams: IDLE=2'd0, SETUP=2'd1, WAIT_ACK=2'd2.
  - Counter-width helper function.
  - These are reused by the matching receive block.
- Sub-module: the common synchronizer module, instantiated with D_WIDTH=1 and SYNC_FF=SYNC_FF on rx_ack, clocked by ck, reset by rn.
- No other hierarchy.

Test Plan:
- Reset release, defaults:
  - After rn 0->1: tx_req=0, tx_data=0, busy=0, timeout_err=0.
  - s_ready=1 on the first cycle after release.
- Single transfer (SETUP_CYC=1, SYNC_FF=2):
  - s_data=64'hDEAD_BEEF_0123_4567 with s_valid at edge E0.
  - tx_data updates at E0; tx_req 0->1 at E1.
  - Loopback of tx_req to rx_ack gives busy=0 and s_ready=1 at E4.
- Back-to-back words:
  - Hold s_valid=1 with words A, B, C under loopback; tx_req toggles 1,0,1.
  - Each word is accepted 5 cycles apart.
  - tx_data holds each word unchanged until its next accept.
- Timeout (TIMEOUT_CYC=8, rx_ack stuck):
  - timeout_err rises 8 cycles after entering WAIT_ACK while busy stays 1.
  - A late rx_ack toggle returns the block to IDLE with timeout_err still 1.
  - err_clr then clears it.
- Reset mid-WAIT_ACK:
  - Assert rn=0 for 1 cycle.
  - tx_req=0, tx_data=0, state IDLE.
  - A new transfer completes normally.
- Stray ack and set/clear collision:
  - Toggle rx_ack while in IDLE: no state change, s_ready stays 1.
  - err_clr=1 on the same edge as a timeout_err set: timeout_err=1.
